// File: rtl/video_pkg.sv
// Shared definitions for the video pixel shifter slice.
//   seq_state_t : fetch sequencer states (IDLE -> SAMPLE -> XFER)
//   SLOT_OFFSET : x[3:0] value of a fetch slot inside each 16-column word
//   PAL_*       : palette entries, packed as {R,G,B}
package video_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_XFER   = 2'd2
    } seq_state_t;

    // Fetch lands three columns before the word boundary: slot at 13,
    // SAMPLE at 14, XFER at 15, first pixel of the new word at 0.
    localparam logic [3:0] SLOT_OFFSET = 4'd13;

    localparam logic [2:0] PAL_BLACK = 3'b000;
    localparam logic [2:0] PAL_BLUE  = 3'b001;
    localparam logic [2:0] PAL_GREEN = 3'b010;
    localparam logic [2:0] PAL_RED   = 3'b100;
    localparam logic [2:0] PAL_WHITE = 3'b111;

endpackage

// File: rtl/video_pixel_shifter_if.sv
// SRAM video-read bus between the pixel shifter and the SRAM arbiter.
//   load       : read request, high for the single cycle of a fetch slot
//   fetch_word : word column addressed while load is high
//   ram_data   : shared SRAM data bus
//   ram_rdy    : ram_data holds the requested video word
// master = pixel shifter, slave = arbiter.
interface video_pixel_shifter_if;

    logic        load;
    logic [4:0]  fetch_word;
    logic [15:0] ram_data;
    logic        ram_rdy;

    modport master (output load, output fetch_word, input ram_data, input ram_rdy);
    modport slave  (input load, input fetch_word, output ram_data, output ram_rdy);

endinterface

// File: rtl/pixel_palette.sv
// Palette decode, purely combinational.
//   code : two LSBs of the shift register
//   mode : 1 = colour 2 bpp, 0 = mono 1 bpp (only code[0] matters)
//   rgb  : {R,G,B}
module pixel_palette
    import video_pkg::*;
(
    input  logic [1:0] code,
    input  logic       mode,
    output logic [2:0] rgb
);

    always_comb begin
        rgb = PAL_BLACK;
        if (mode) begin
            case (code)
                2'b00:   rgb = PAL_BLACK;
                2'b01:   rgb = PAL_BLUE;
                2'b10:   rgb = PAL_GREEN;
                default: rgb = PAL_RED;
            endcase
        end else if (code[0]) begin
            rgb = PAL_WHITE;
        end
    end

endmodule

// File: rtl/video_pixel_shifter.sv
// Video pixel shifter: fetches one 16-bit word per 16 columns from the
// shared SRAM and serialises it to R/G/B, mono (1 bpp) or colour (2 bpp).
//   clk25, reset_n : pixel clock, synchronous active-low reset
//   x, valid       : column and visible-window flag from the sync generator
//   color          : mode select, taken only on a word boundary
//   clr_underrun   : clears the sticky underrun flag
//   ram            : SRAM read bus (load/fetch_word out, ram_data/ram_rdy in)
//   R, G, B        : registered pixel, one cycle after its column on x
//   underrun       : sticky, set when the arbiter missed a fetch
module video_pixel_shifter
    import video_pkg::*;
#(
    parameter int H_TOTAL   = 800,
    parameter int H_VISIBLE = 512
) (
    input  logic                        clk25,
    input  logic                        reset_n,
    input  logic [9:0]                  x,
    input  logic                        valid,
    input  logic                        color,
    input  logic                        clr_underrun,
    video_pixel_shifter_if.master       ram,
    output logic                        R,
    output logic                        G,
    output logic                        B,
    output logic                        underrun
);

    // Last in-line slot fetches the final visible word; the end-of-line
    // slot prefetches word 0 of the next line.
    localparam logic [9:0] LAST_SLOT_X = 10'(H_VISIBLE - 19);
    localparam logic [9:0] EOL_SLOT_X  = 10'(H_TOTAL - 3);

    seq_state_t  state;
    logic [15:0] hold_q;
    logic [15:0] shift_q;
    logic        mode_q;
    logic        phase_q;      // colour: second cycle of the current pair
    logic [4:0]  fetch_word_q;

    logic        eol_slot;
    logic        slot;
    logic        load_c;
    logic [4:0]  fetch_word_c;
    logic [2:0]  rgb;

    assign eol_slot = (x == EOL_SLOT_X);
    assign slot     = eol_slot || ((x[3:0] == SLOT_OFFSET) && (x <= LAST_SLOT_X));

    // The request must coincide with the slot column itself, so load is
    // decoded from x; slots are only honoured while the sequencer is idle.
    assign load_c       = reset_n && (state == ST_IDLE) && slot;
    assign fetch_word_c = eol_slot ? 5'd0 : x[8:4] + 5'd1;

    assign ram.load       = load_c;
    assign ram.fetch_word = load_c ? fetch_word_c : fetch_word_q;

    pixel_palette u_palette (
        .code (shift_q[1:0]),
        .mode (mode_q),
        .rgb  (rgb)
    );

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            hold_q       <= '0;
            shift_q      <= '0;
            mode_q       <= 1'b0;
            phase_q      <= 1'b0;
            fetch_word_q <= '0;
            R            <= 1'b0;
            G            <= 1'b0;
            B            <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_c) begin
                        state        <= ST_SAMPLE;
                        fetch_word_q <= fetch_word_c;
                    end
                end
                ST_SAMPLE: begin
                    // A missed fetch renders the word black.
                    hold_q <= ram.ram_rdy ? ram.ram_data : 16'h0000;
                    state  <= ST_XFER;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Word boundary: new word and new mode take effect together.
            if (state == ST_XFER) begin
                shift_q <= hold_q;
                mode_q  <= color;
                phase_q <= 1'b0;
            end else if (mode_q) begin
                phase_q <= ~phase_q;
                if (phase_q) shift_q <= shift_q >> 2;
            end else begin
                shift_q <= shift_q >> 1;
            end

            {R, G, B} <= valid ? rgb : PAL_BLACK;

            // Set has priority over clear.
            if ((state == ST_SAMPLE) && !ram.ram_rdy) underrun <= 1'b1;
            else if (clr_underrun)                    underrun <= 1'b0;
        end
    end

endmodule

// File: doc/video_pixel_shifter.md
VIDEO_PIXEL_SHIFTER -- requirements
Module: video_pixel_shifter

Interface
REQ-001 The block SHALL have parameter H_TOTAL, default 800, meaning pixel clocks per scan line.
REQ-002 The block SHALL have parameter H_VISIBLE, default 512, meaning visible pixel columns; it SHALL be a multiple of 16.
REQ-003 Port clk25  in  1  pixel clock; the block has one clock and uses only its rising edge.
REQ-004 Port reset_n  in  1  reset, synchronous and active-low.
REQ-005 Port x  in  10  current column from the sync generator, 0..H_TOTAL-1.
REQ-006 Port valid  in  1  high inside the visible window.
REQ-007 Port color  in  1  mode select: 1 = colour 2 bpp, 0 = mono 1 bpp.
REQ-008 Port ram_data  in  16  shared SRAM data bus.
REQ-009 Port ram_rdy  in  1  arbiter indication that ram_data holds the requested video word.
REQ-010 Port clr_underrun  in  1  clears the sticky underrun flag.
REQ-011 Port load  out  1  video read request to the SRAM arbiter.
REQ-012 Port fetch_word  out  5  word column to address during load.
REQ-013 Ports R, G, B  out  1 each  registered pixel colour.
REQ-014 Port underrun  out  1  sticky flag set by a missed fetch.

Function
REQ-015 Fetch slots SHALL be x[3:0]==13 with x <= H_VISIBLE-19, plus x == H_TOTAL-3; this gives 32 slots per line at the defaults.
REQ-016 load SHALL be high for exactly the one cycle of each fetch slot and low at all other times.
REQ-017 fetch_word SHALL be 0 in the H_TOTAL-3 slot and x[8:4]+1 in every other slot; it SHALL hold its last value outside slots.
REQ-018 In the cycle after a slot (the SAMPLE cycle), the block SHALL capture ram_data into a holding register if ram_rdy=1.
REQ-019 If ram_rdy=0 in SAMPLE, the block SHALL load 16'h0000 into the holding register and set underrun.
REQ-020 In the cycle after SAMPLE (the XFER cycle, x[3:0]==15), the holding register SHALL transfer to the shift register.
REQ-021 Mono mode: each cycle SHALL emit shift bit 0 and then shift right by 1 (LSB = leftmost pixel). Bit=1 gives R=G=B=1; bit=0 gives black.
REQ-022 Colour mode: the pair {bit1,bit0} SHALL be emitted for 2 cycles, then the register shifts right by 2. Mapping: 00 black, 01 B, 10 G, 11 R.
REQ-023 The color input SHALL be sampled only at XFER, so the mode can change only on a word boundary.
REQ-024 Latency: the pixel for the column presented on x in cycle n SHALL appear on R/G/B at cycle n+1.
REQ-025 If valid=0, R/G/B SHALL be 0 in the next cycle regardless of shift contents. The shift register keeps shifting.
REQ-026 The sequencer SHALL be an explicit 3-state FSM: IDLE -> SAMPLE on a fetch slot; SAMPLE -> XFER unconditionally; XFER -> IDLE unconditionally.
REQ-027 If x jumps (resync) while the FSM is in SAMPLE or XFER, the FSM SHALL complete its sequence. Slot detection SHALL be re-evaluated only in IDLE.
REQ-028 underrun SHALL stay set until clr_underrun=1. If set and clear coincide, set SHALL win.

Reset
REQ-029 While reset_n=0 at a clock edge, the following SHALL be cleared: FSM to IDLE, holding and shift registers to 0, load=0, fetch_word=0, R=G=B=0, underrun=0.
REQ-030 Reset asserted mid-line SHALL abort any in-flight fetch without a SAMPLE capture. After release, the first fetch SHALL occur at the next qualifying slot.

Structure
REQ-031 FSM state encoding, the palette constants and the slot offset constant (13) SHALL reside in the shared package video_pkg.
REQ-032 Palette decode SHALL be one sub-module, pixel_palette: 2-bit code + mode -> RGB, purely combinational.
REQ-033 No other sub-modules SHALL be used. All state SHALL be on clk25.

Verification
REQ-034 Mono line: ram_data=16'h0001 for every word, ram_rdy=1, valid for x<512. Required response: R/G/B=1 at cycles x+1 for x = 0, 16, ..., 496; black otherwise; 32 load pulses per line.
REQ-035 Colour word 16'h00E4 (pairs 00,01,10,11 from LSB) at word 0. Required response: columns 0-1 black, 2-3 B, 4-5 G, 6-7 R, 8-15 black.
REQ-036 Fetch addressing. Required response: load pulses at x = 797, 13, 29, ..., 493 with fetch_word = 0, 1, 2, ..., 31 respectively.
REQ-037 ram_rdy=0 during the SAMPLE cycle of the slot at x=29. Required response: columns 32-47 black and underrun=1. It stays 1 across lines and clears one cycle after clr_underrun.
REQ-038 reset_n=0 asserted at x=14 (SAMPLE) for 1 cycle. Required response: no capture; R/G/B=0; the next load occurs at x=29; outputs are at reset values.
REQ-039 color toggled at x=5. Required response: word 0 is rendered fully in the old mode, and the new mode takes effect from column 16.
